mem_xfer: RTL
=============

MEM_XFER -- requirements
Module: mem_xfer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: request pulse, accepted only when idle.
REQ-004 SHALL have port op, input, 2: operation select; 0 STORE (FX55), 1 LOAD (FX65), 2 BCD (FX33), 3 reserved.
REQ-005 SHALL have port x, input, 4: last register index; BCD source index.
REQ-006 SHALL have port i_addr, input, 12: I register value.
REQ-007 SHALL have port vx_in, input, 8: Vx value for BCD.
REQ-008 SHALL have ports reg_rd_idx, output, 4 and reg_rd_data, input, 8: combinational register-file read.
REQ-009 SHALL have ports reg_wr_en, output, 1; reg_wr_idx, output, 4; reg_wr_data, output, 8: register-file write strobe.
REQ-010 SHALL have ports mem_we, output, 1; mem_addr, output, 12; mem_wdata, output, 8; mem_read_len, output, 4: memory request.
REQ-011 SHALL have port mem_rdata, input, 120: registered read bus; byte k of an N-byte read sits at bits [8*(N-k)-1 -: 8].
REQ-012 SHALL have ports busy, output, 1 and done, output, 1.
REQ-013 SHALL have ports i_wr_en, output, 1 and i_wr_data, output, 12: I register update.

Function
REQ-014 SHALL latch op, x, i_addr and vx_in on the cycle start is accepted; busy SHALL rise the next cycle.
REQ-015 SHALL ignore start while busy is high.
REQ-016 SHALL implement states IDLE, STORE, LOAD_REQ, LOAD_CAP, LOAD_WB, BCD, DONE.
REQ-017 STORE SHALL take x+1 cycles; in cycle k it SHALL drive reg_rd_idx=k, mem_we=1, mem_addr=i+k, mem_wdata=reg_rd_data.
REQ-018 LOAD_REQ SHALL drive mem_we=0, mem_addr=i+base, mem_read_len=min(x+1-base,15); base starts at 0.
REQ-019 LOAD_CAP, the cycle after LOAD_REQ, SHALL capture mem_rdata into an internal 120-bit buffer.
REQ-020 LOAD_WB SHALL write one register per cycle, reg_wr_idx=base+k, data=buffer byte k, for each byte of the chunk.
REQ-021 If x=15, then after 15 writebacks it SHALL set base=15 and run REQ, CAP and WB once more with length 1.
REQ-022 BCD SHALL take 3 cycles of mem_we=1 at i, i+1, i+2, writing hundreds, tens and ones of the latched vx_in.
REQ-023 DONE SHALL last exactly one cycle with done=1; IDLE follows.
REQ-024 op=3 SHALL go directly to DONE with no memory or register writes.
REQ-025 All address arithmetic SHALL wrap modulo 4096.
REQ-026 mem_we and reg_wr_en SHALL be 0 outside their write states; mem_read_len SHALL be 0 except during LOAD_REQ and LOAD_CAP.

Reset
REQ-027 On rst, state SHALL become IDLE and busy, done, mem_we, reg_wr_en, i_wr_en, mem_read_len SHALL be 0, even mid-operation, with no further writes.
REQ-028 Address and data outputs SHALL reset to 0.

Configuration
REQ-029 With CHIP8_I_INCR_EN defined, DONE after STORE or LOAD SHALL pulse i_wr_en with i_wr_data=i+x+1 mod 4096 (COSMAC quirk).
REQ-030 Without CHIP8_I_INCR_EN, i_wr_en SHALL be constant 0 and i_wr_data 0.

Structure
REQ-031 Package chip8_pkg SHALL hold op encodings, ADDR_W=12, MAX_READ_LEN=15 and the state typedef.
REQ-032 BCD digit extraction SHALL be a combinational sub-module bcd_conv: 8-bit in, three 4-bit digits out.

Verification
REQ-033 STORE x=2, I=0x300, V0..V2=0x11,0x22,0x33: writes at 0x300..0x302 with those values on 3 consecutive cycles; done 1 cycle later.
REQ-034 LOAD x=15, I=0x400, memory = 0x00..0x0F: one 15-byte read, then one 1-byte read at 0x40F; V0..VF = 0x00..0x0F.
REQ-035 BCD vx_in=0xFE (254): writes 2, 5, 4 at I, I+1, I+2.
REQ-036 STORE x=3, I=0xFFE: addresses 0xFFE, 0xFFF, 0x000, 0x001; with CHIP8_I_INCR_EN, i_wr_data=0x002.
REQ-037 Assert rst during cycle 2 of LOAD x=5: no reg_wr_en afterwards, busy=0 next cycle; start pulsed while busy is ignored.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 memory transfer unit (FX55 / FX65 / FX33).
// Operation encodings, bus widths, the transfer FSM state type and small
// helpers for chunked register loads live here.
package chip8_pkg;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 8;
    localparam int IDX_W        = 4;
    localparam int MAX_READ_LEN = 15;
    localparam int BUF_W        = DATA_W * MAX_READ_LEN;

    typedef enum logic [1:0] {
        OP_STORE = 2'd0,
        OP_LOAD  = 2'd1,
        OP_BCD   = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD_REQ,
        LOAD_CAP,
        LOAD_WB,
        BCD,
        DONE
    } state_e;

    // Bytes still to load (last index + 1 - base), clamped to one read burst.
    function automatic logic [IDX_W-1:0] read_len(input logic [IDX_W-1:0] last,
                                                  input logic [IDX_W:0]   base);
        logic [IDX_W:0] remaining;
        remaining = {1'b0, last} + 5'd1 - base;
        if (remaining > 5'(MAX_READ_LEN))
            return 4'(MAX_READ_LEN);
        return remaining[IDX_W-1:0];
    endfunction

    // Byte k of an n-byte burst; the first byte occupies the highest used lane.
    function automatic logic [DATA_W-1:0] buf_byte(input logic [BUF_W-1:0] data,
                                                   input logic [IDX_W-1:0] n,
                                                   input logic [IDX_W-1:0] k);
        int sh;
        sh = DATA_W * (int'(n) - 1 - int'(k));
        return 8'(data >> sh);
    endfunction

endpackage

// File: rtl/bcd_conv.sv
// Combinational binary-to-BCD conversion of an 8-bit value into
// hundreds, tens and ones digits.
module bcd_conv
    import chip8_pkg::*;
(
    input  logic [DATA_W-1:0] bin_i,
    output logic [3:0]        hundreds_o,
    output logic [3:0]        tens_o,
    output logic [3:0]        ones_o
);

    // Constant divisors keep this a pure arithmetic network.
    always_comb begin
        hundreds_o = 4'(bin_i / 8'd100);
        tens_o     = 4'((bin_i / 8'd10) % 8'd10);
        ones_o     = 4'(bin_i % 8'd10);
    end

endmodule

// File: rtl/mem_xfer.sv
// CHIP-8 memory transfer engine: FX55 register store, FX65 register load in
// bursts of up to 15 bytes, and FX33 BCD store. Optional macro
// CHIP8_I_INCR_EN enables the COSMAC quirk that advances I by x+1 after
// store/load; without it the I update port is tied off.
module mem_xfer
    import chip8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [IDX_W-1:0]  x,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] vx_in,
    output logic [IDX_W-1:0]  reg_rd_idx,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              reg_wr_en,
    output logic [IDX_W-1:0]  reg_wr_idx,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [IDX_W-1:0]  mem_read_len,
    input  logic [BUF_W-1:0]  mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              i_wr_en,
    output logic [ADDR_W-1:0] i_wr_data
);

    state_e              state_q;
    op_e                 op_q;
    logic [IDX_W-1:0]    x_q;
    logic [ADDR_W-1:0]   i_q;
    logic [DATA_W-1:0]   vx_q;
    logic [IDX_W-1:0]    k_q;
    logic [IDX_W-1:0]    base_q;
    logic [IDX_W-1:0]    len_q;
    logic [BUF_W-1:0]    buf_q;

    logic                busy_q;
    logic                done_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [IDX_W-1:0]    mem_read_len_q;
    logic [IDX_W-1:0]    reg_rd_idx_q;
    logic                reg_wr_en_q;
    logic [IDX_W-1:0]    reg_wr_idx_q;
    logic [DATA_W-1:0]   reg_wr_data_q;
`ifdef CHIP8_I_INCR_EN
    logic                i_wr_en_q;
    logic [ADDR_W-1:0]   i_wr_data_q;
`endif

    logic [DATA_W-1:0]   bcd_src;
    logic [3:0]          hundreds;
    logic [3:0]          tens;
    logic [3:0]          ones;
    logic [IDX_W:0]      next_base;

    // The first BCD digit is produced on the accept cycle, before vx_q holds it.
    assign bcd_src   = (state_q == IDLE) ? vx_in : vx_q;
    assign next_base = {1'b0, base_q} + {1'b0, len_q};

    bcd_conv u_bcd (
        .bin_i      (bcd_src),
        .hundreds_o (hundreds),
        .tens_o     (tens),
        .ones_o     (ones)
    );

    // Transfer FSM; every output register is loaded with its value for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            op_q           <= OP_STORE;
            x_q            <= '0;
            i_q            <= '0;
            vx_q           <= '0;
            k_q            <= '0;
            base_q         <= '0;
            len_q          <= '0;
            buf_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_read_len_q <= '0;
            reg_rd_idx_q   <= '0;
            reg_wr_en_q    <= 1'b0;
            reg_wr_idx_q   <= '0;
            reg_wr_data_q  <= '0;
`ifdef CHIP8_I_INCR_EN
            i_wr_en_q      <= 1'b0;
            i_wr_data_q    <= '0;
`endif
        end else begin
            done_q         <= 1'b0;
            mem_we_q       <= 1'b0;
            reg_wr_en_q    <= 1'b0;
            mem_read_len_q <= '0;
`ifdef CHIP8_I_INCR_EN
            i_wr_en_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q       <= op_e'(op);
                        x_q        <= x;
                        i_q        <= i_addr;
                        vx_q       <= vx_in;
                        k_q        <= '0;
                        base_q     <= '0;
                        busy_q     <= 1'b1;
                        mem_addr_q <= i_addr;
                        case (op_e'(op))
                            OP_STORE: begin
                                state_q      <= STORE;
                                mem_we_q     <= 1'b1;
                                reg_rd_idx_q <= '0;
                            end
                            OP_LOAD: begin
                                state_q        <= LOAD_REQ;
                                mem_read_len_q <= read_len(x, 5'd0);
                            end
                            OP_BCD: begin
                                state_q     <= BCD;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= {4'd0, hundreds};
                            end
                            default: begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                STORE: begin
                    if (k_q == x_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
`ifdef CHIP8_I_INCR_EN
                        i_wr_en_q   <= 1'b1;
                        i_wr_data_q <= i_q + {8'd0, x_q} + 12'd1;
`endif
                    end else begin
                        k_q          <= k_q + 4'd1;
                        mem_we_q     <= 1'b1;
                        mem_addr_q   <= mem_addr_q + 12'd1;
                        reg_rd_idx_q <= k_q + 4'd1;
                    end
                end
                LOAD_REQ: begin
                    state_q        <= LOAD_CAP;
                    mem_read_len_q <= mem_read_len_q;
                end
                LOAD_CAP: begin
                    state_q       <= LOAD_WB;
                    buf_q         <= mem_rdata;
                    len_q         <= mem_read_len_q;
                    k_q           <= '0;
                    reg_wr_en_q   <= 1'b1;
                    reg_wr_idx_q  <= base_q;
                    reg_wr_data_q <= buf_byte(mem_rdata, mem_read_len_q, 4'd0);
                end
                LOAD_WB: begin
                    if (k_q + 4'd1 == len_q) begin
                        if (next_base <= {1'b0, x_q}) begin
                            state_q        <= LOAD_REQ;
                            base_q         <= next_base[IDX_W-1:0];
                            mem_addr_q     <= i_q + {7'd0, next_base};
                            mem_read_len_q <= read_len(x_q, next_base);
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
`ifdef CHIP8_I_INCR_EN
                            i_wr_en_q   <= 1'b1;
                            i_wr_data_q <= i_q + {8'd0, x_q} + 12'd1;
`endif
                        end
                    end else begin
                        k_q           <= k_q + 4'd1;
                        reg_wr_en_q   <= 1'b1;
                        reg_wr_idx_q  <= base_q + k_q + 4'd1;
                        reg_wr_data_q <= buf_byte(buf_q, len_q, k_q + 4'd1);
                    end
                end
                BCD: begin
                    if (k_q == 4'd2) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        k_q         <= k_q + 4'd1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= mem_addr_q + 12'd1;
                        mem_wdata_q <= {4'd0, (k_q == 4'd0) ? tens : ones};
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Store data comes straight from the register file read port in the same cycle.
    assign mem_wdata    = (mem_we_q && op_q == OP_STORE) ? reg_rd_data : mem_wdata_q;
    assign reg_rd_idx   = reg_rd_idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_read_len = mem_read_len_q;
    assign reg_wr_en    = reg_wr_en_q;
    assign reg_wr_idx   = reg_wr_idx_q;
    assign reg_wr_data  = reg_wr_data_q;
`ifdef CHIP8_I_INCR_EN
    assign i_wr_en      = i_wr_en_q;
    assign i_wr_data    = i_wr_data_q;
`else
    assign i_wr_en      = 1'b0;
    assign i_wr_data    = '0;
`endif

endmodule
